// File: rtl/sl3p_tx_lane_framer.sv
// sl3p_tx_lane_framer: stripes a user word stream across serdes lanes as
// 66-bit blocks, pads empty slots with idles, and inserts aligned per-lane
// markers every MARKER_PERIOD phase slots after an idle warmup.
module sl3p_tx_lane_framer #(
  parameter int unsigned LANES         = 2,
  parameter int unsigned MARKER_PERIOD = 16384,
  parameter int unsigned WARMUP_WORDS  = 64,
  parameter int unsigned SEQ_BITS      = 16
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  tx_phase,
  input  logic [LANES*64-1:0]   din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [LANES*66-1:0]   tx_din,
  output logic                  marker_pulse,
  output logic [SEQ_BITS-1:0]   marker_seq,
  output logic                  warm_done
);

  localparam int unsigned TW     = LANES * 66;
  localparam int unsigned SLOT_W = (MARKER_PERIOD > 1) ? $clog2(MARKER_PERIOD) : 1;
  localparam int unsigned WARM_W = (WARMUP_WORDS > 1) ? $clog2(WARMUP_WORDS) : 1;

  localparam logic [1:0]  HDR_DATA     = 2'b01;
  localparam logic [1:0]  HDR_CTRL     = 2'b10;
  localparam logic [63:0] IDLE_PAYLOAD = 64'h1E00_0000_0000_0000;
  localparam logic [7:0]  MRK_TAG      = 8'h4B;
  localparam logic [15:0] MRK_SYNC     = 16'hA55A;
  localparam logic [65:0] IDLE_BLOCK   = {IDLE_PAYLOAD, HDR_CTRL};
  localparam logic [TW-1:0] IDLE_ALL   = {LANES{IDLE_BLOCK}};

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(MARKER_PERIOD - 1);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_WORDS - 1);

  typedef enum logic {
    ST_WARM = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [WARM_W-1:0]     warm_cnt_q, warm_cnt_d;
  logic [SLOT_W-1:0]     slot_cnt_q, slot_cnt_d;
  logic [SEQ_BITS-1:0]   seq_q, seq_d;
  logic [TW-1:0]         tx_din_q, tx_din_d;
  logic                  marker_pulse_q, marker_pulse_d;
  logic [SEQ_BITS-1:0]   marker_seq_q, marker_seq_d;
  logic                  warm_done_q, warm_done_d;

  // Marker block on every lane for the given sequence number.
  function automatic logic [TW-1:0] marker_blocks(input logic [SEQ_BITS-1:0] seq);
    logic [TW-1:0] r;
    logic [15:0]   s;
    r = '0;
    s = 16'(seq);
    for (int l = 0; l < int'(LANES); l++) begin
      r[l*66 +: 66] = {MRK_TAG, 8'(l), MRK_SYNC, s, ~s, HDR_CTRL};
    end
    return r;
  endfunction

  // Data blocks: each lane carries its own 64-bit slice of the user word.
  function automatic logic [TW-1:0] data_blocks(input logic [LANES*64-1:0] word);
    logic [TW-1:0] r;
    r = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      r[l*66 +: 66] = {word[l*64 +: 64], HDR_DATA};
    end
    return r;
  endfunction

  // Words are only taken on a non-marker phase slot once running.
  assign din_ready = tx_phase && (state_q == ST_RUN) && (slot_cnt_q != '0);

  // Next-state and next-output decode; nothing moves without tx_phase.
  always_comb begin
    state_d        = state_q;
    warm_cnt_d     = warm_cnt_q;
    slot_cnt_d     = slot_cnt_q;
    seq_d          = seq_q;
    tx_din_d       = tx_din_q;
    marker_pulse_d = 1'b0;
    marker_seq_d   = marker_seq_q;
    warm_done_d    = warm_done_q;

    if (tx_phase) begin
      case (state_q)
        ST_WARM: begin
          tx_din_d = IDLE_ALL;
          if (warm_cnt_q == WARM_LAST) begin
            state_d     = ST_RUN;
            slot_cnt_d  = '0;
            warm_done_d = 1'b1;
          end else begin
            warm_cnt_d = warm_cnt_q + WARM_W'(1);
          end
        end
        ST_RUN: begin
          if (slot_cnt_q == '0) begin
            tx_din_d       = marker_blocks(seq_q);
            marker_pulse_d = 1'b1;
            marker_seq_d   = seq_q;
            seq_d          = seq_q + SEQ_BITS'(1);
          end else if (din_valid) begin
            tx_din_d = data_blocks(din);
          end else begin
            tx_din_d = IDLE_ALL;
          end
          slot_cnt_d = (slot_cnt_q == SLOT_LAST) ? '0 : slot_cnt_q + SLOT_W'(1);
        end
        default: begin
          state_d = ST_WARM;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ST_WARM;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters and registered outputs.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      warm_cnt_q     <= '0;
      slot_cnt_q     <= '0;
      seq_q          <= '0;
      tx_din_q       <= IDLE_ALL;
      marker_pulse_q <= 1'b0;
      marker_seq_q   <= '0;
      warm_done_q    <= 1'b0;
    end else begin
      warm_cnt_q     <= warm_cnt_d;
      slot_cnt_q     <= slot_cnt_d;
      seq_q          <= seq_d;
      tx_din_q       <= tx_din_d;
      marker_pulse_q <= marker_pulse_d;
      marker_seq_q   <= marker_seq_d;
      warm_done_q    <= warm_done_d;
    end
  end

  assign tx_din       = tx_din_q;
  assign marker_pulse = marker_pulse_q;
  assign marker_seq   = marker_seq_q;
  assign warm_done    = warm_done_q;

endmodule
